// File: rtl/ddr_buf_pkg.sv
// Shared types and helpers for the DDR write buffer.
package ddr_buf_pkg;

  // Largest burst the buffer releases in one go (burst_size = 3).
  localparam int MAX_BURST = 8;

  // Width of beat counters; holds values 0..MAX_BURST.
  localparam int BEAT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Beats per burst for an encoded burst size: 1, 2, 4 or 8.
  function automatic logic [BEAT_W-1:0] burst_beats(input logic [1:0] size);
    return BEAT_W'(1) << size;
  endfunction

endpackage

// File: rtl/ddr_wbuf_fifo.sv
// Beat storage for the DDR write buffer: circular array with wrap-bit
// pointers, registered occupancy and a full flag decoded from it.
module ddr_wbuf_fifo
  import ddr_buf_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_req_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     pop_i,
  output logic                     wfull_o,
  output logic [ADDR_W-1:0]        rd_addr_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [ADDR_W+DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W-1:0] count_q, count_d;
  logic             push_en;

  // Full comes straight from the registered count; a pop in the same cycle
  // does not free a slot for the incoming beat.
  assign wfull_o = (count_q == PTR_W'(DEPTH));
  assign push_en = push_req_i && !wfull_o;

  // Next occupancy: a push and a pop in the same cycle cancel out.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    count_d = count_q;
    if (push_en && !pop_i) begin
      count_d = count_q + 1'b1;
    end else if (!push_en && pop_i) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers; reset empties the buffer at once.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + 1'b1;
      if (pop_i)   rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Beat storage write port.
  // NOTE: the array has no reset; stale entries are unreachable because the pointers and count are reset.
  always_ff @(posedge clk) begin
    if (push_en) mem[wptr_q[IDX_W-1:0]] <= {waddr_i, wdata_i};
  end

  // Head entry is read combinationally so it is valid in the same cycle.
  assign {rd_addr_o, rd_data_o} = mem[rptr_q[IDX_W-1:0]];
  assign count_o = count_q;

endmodule

// File: rtl/ddr_write_buffer.sv
// DDR write buffer: collects beats from the AXI write path and releases
// them to the DDR scheduler only as complete bursts of 1 << burst_size.
module ddr_write_buffer
  import ddr_buf_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   wstrobe,
  output logic                   wfull,
  output logic                   werr,
  input  logic [1:0]             burst_size,
  output logic                   dq_valid,
  input  logic                   dq_ready,
  output logic [ADDR_W-1:0]      dq_addr,
  output logic [DATA_W-1:0]      dq_data,
  output logic                   dq_last,
  output logic [$clog2(DEPTH):0] count
);

  localparam int COUNT_W = $clog2(DEPTH) + 1;

  state_t            state_q;
  logic [BEAT_W-1:0] beat_cnt_q;
  logic [BEAT_W-1:0] beats_lat_q;
  logic              dq_valid_q;
  logic              dq_last_q;
  logic              werr_q;
  logic              handshake;
  logic [BEAT_W-1:0] req_beats;

  assign handshake = dq_valid_q && dq_ready;
  assign req_beats = burst_beats(burst_size);

  ddr_wbuf_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_req_i (wstrobe),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .pop_i      (handshake),
    .wfull_o    (wfull),
    .rd_addr_o  (dq_addr),
    .rd_data_o  (dq_data),
    .count_o    (count)
  );

  // Burst sequencer: waits in IDLE until a whole burst is buffered, then
  // streams exactly that many beats; burst length is frozen on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      beats_lat_q <= '0;
      dq_valid_q  <= 1'b0;
      dq_last_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count >= COUNT_W'(req_beats)) begin
            state_q     <= BURST;
            beats_lat_q <= req_beats;
            beat_cnt_q  <= '0;
            dq_valid_q  <= 1'b1;
            dq_last_q   <= (req_beats == BEAT_W'(1));
          end
        end
        BURST: begin
          if (handshake) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (dq_last_q) begin
              state_q    <= IDLE;
              dq_valid_q <= 1'b0;
              dq_last_q  <= 1'b0;
            end else begin
              dq_last_q <= (beat_cnt_q + 1'b1 == beats_lat_q - 1'b1);
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          dq_valid_q <= 1'b0;
          dq_last_q  <= 1'b0;
        end
      endcase
    end
  end

  // Overflow flag: a beat offered while full is dropped and flagged for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      werr_q <= 1'b0;
    end else begin
      werr_q <= wstrobe && wfull;
    end
  end

  assign dq_valid = dq_valid_q;
  assign dq_last  = dq_last_q;
  assign werr     = werr_q;

endmodule

// File: tb/tb_ddr_write_buffer.sv
// Self-checking bench for ddr_write_buffer: a queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_ddr_write_buffer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              wstrobe;
  logic              wfull;
  logic              werr;
  logic [1:0]        burst_size;
  logic              dq_valid;
  logic              dq_ready;
  logic [ADDR_W-1:0] dq_addr;
  logic [DATA_W-1:0] dq_data;
  logic              dq_last;
  logic [CW-1:0]     count;

  int checks   = 0;
  int failures = 0;

  ddr_write_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .waddr      (waddr),
    .wdata      (wdata),
    .wstrobe    (wstrobe),
    .wfull      (wfull),
    .werr       (werr),
    .burst_size (burst_size),
    .dq_valid   (dq_valid),
    .dq_ready   (dq_ready),
    .dq_addr    (dq_addr),
    .dq_data    (dq_data),
    .dq_last    (dq_last),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dat(input logic [7:0] a);
    return {24'hC0DE00, a, 24'h5A5A00, a};
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0]  a;
    logic [63:0] d;
  } beat_t;

  beat_t mq[$];
  int    m_rem  = 0;   // beats still owed in the current burst; 0 = idle
  logic  m_werr = 1'b0;

  always @(posedge clk or posedge rst) begin
    int sz;
    int nrem;
    bit do_push;
    bit do_pop;
    if (rst) begin
      mq.delete();
      m_rem  = 0;
      m_werr = 1'b0;
    end else begin
      sz      = mq.size();
      do_push = wstrobe && (sz < DEPTH);
      do_pop  = (m_rem > 0) && dq_ready;
      m_werr  = wstrobe && (sz >= DEPTH);
      nrem    = m_rem;
      if (m_rem == 0) begin
        if (sz >= (1 << burst_size)) nrem = 1 << burst_size;
      end else if (do_pop) begin
        nrem = m_rem - 1;
      end
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(beat_t'{a: waddr, d: wdata});
      m_rem = nrem;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("m_valid", dq_valid, m_rem > 0);
      check("m_last",  dq_last,  m_rem == 1);
      check("m_count", count,    mq.size());
      check("m_wfull", wfull,    mq.size() == DEPTH);
      check("m_werr",  werr,     m_werr);
      if (m_rem > 0) begin
        check("m_addr", dq_addr, mq[0].a);
        check("m_data", dq_data, mq[0].d);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct packed {
    logic        last;
    logic [7:0]  a;
    logic [63:0] d;
  } obs_t;

  obs_t got[$];

  // Drive one cycle; log the beat that the coming edge will hand off.
  task automatic step(input logic ws, input logic [7:0] a, input logic [63:0] d, input logic rdy);
    wstrobe  = ws;
    waddr    = a;
    wdata    = d;
    dq_ready = rdy;
    if (dq_valid && rdy) got.push_back(obs_t'{last: dq_last, a: dq_addr, d: dq_data});
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] a, input logic rdy);
    step(1'b1, a, dat(a), rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, rdy);
  endtask

  // Handed-off beats must be base, base+1, ... with last closing each blen group.
  task automatic check_bursts(input string tag, input logic [7:0] base, input int n, input int blen);
    check({tag, "_n"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      check({tag, "_addr"}, got[i].a, 8'(base + i));
      check({tag, "_last"}, got[i].last, (i % blen) == blen - 1);
      check({tag, "_data"}, got[i].d, dat(8'(base + i)));
    end
    got.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  logic [63:0] prev_data;
  logic [7:0]  prev_addr;

  initial begin
    rst        = 1'b1;
    wstrobe    = 1'b0;
    waddr      = '0;
    wdata      = '0;
    burst_size = 2'd0;
    dq_ready   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", dq_valid, 1'b0);
    check("rst_wfull", wfull, 1'b0);
    check("rst_werr",  werr, 1'b0);
    check("rst_count", count, 0);
    idle(2, 1'b0);

    // Single-beat burst latency.
    burst_size = 2'd0;
    step(1'b1, 8'h10, 64'hA5A5_0000_0000_0001, 1'b1);
    check("lat_valid_n", dq_valid, 1'b0);
    check("lat_count_n", count, 1);
    step(1'b0, '0, '0, 1'b1);
    check("lat_valid", dq_valid, 1'b1);
    check("lat_addr",  dq_addr, 8'h10);
    check("lat_data",  dq_data, 64'hA5A5_0000_0000_0001);
    check("lat_last",  dq_last, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    check("lat_valid_done", dq_valid, 1'b0);
    check("lat_count_done", count, 0);
    got.delete();

    // 4-beat burst waits for the 4th beat; output holds under back-pressure.
    burst_size = 2'd2;
    push(8'h20, 1'b0);
    push(8'h21, 1'b0);
    push(8'h22, 1'b0);
    idle(2, 1'b0);
    check("b4_wait_valid", dq_valid, 1'b0);
    check("b4_wait_count", count, 3);
    push(8'h23, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if ((i % 2 == 1) && dq_valid) begin
        prev_data = dq_data;
        prev_addr = dq_addr;
        step(1'b0, '0, '0, 1'b0);
        check("b4_hold_data", dq_data, prev_data);
        check("b4_hold_addr", dq_addr, prev_addr);
      end else begin
        step(1'b0, '0, '0, i % 2 == 0);
      end
    end
    check_bursts("b4", 8'h20, 4, 4);

    // Fill to full, overflow, then drain as two 8-beat bursts.
    burst_size = 2'd3;
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i), 1'b0);
    check("full_count", count, 16);
    check("full_wfull", wfull, 1'b1);
    check("full_valid", dq_valid, 1'b1);
    check("full_head",  dq_addr, 8'h40);
    push(8'h50, 1'b0);
    check("ovf_werr",  werr, 1'b1);
    check("ovf_count", count, 16);
    idle(1, 1'b0);
    check("ovf_werr_clr", werr, 1'b0);
    idle(24, 1'b1);
    check_bursts("drain", 8'h40, 16, 8);
    check("drain_count", count, 0);

    // burst_size change mid-burst only affects the next burst.
    burst_size = 2'd3;
    for (int i = 0; i < 8; i++) push(8'(8'h60 + i), 1'b0);
    idle(1, 1'b0);
    check("cfg_valid", dq_valid, 1'b1);
    idle(2, 1'b1);
    burst_size = 2'd0;
    idle(10, 1'b1);
    check_bursts("cfg8", 8'h60, 8, 8);
    push(8'h70, 1'b1);
    push(8'h71, 1'b1);
    idle(6, 1'b1);
    check_bursts("cfg1", 8'h70, 2, 1);

    // Push and pop together at count 10 during a burst, across pointer wrap.
    burst_size = 2'd3;
    for (int i = 0; i < 10; i++) push(8'(8'h80 + i), 1'b0);
    check("pp_count_pre", count, 10);
    check("pp_valid_pre", dq_valid, 1'b1);
    push(8'h8A, 1'b1);
    check("pp_count_post", count, 10);
    idle(12, 1'b1);
    check("pp_rest_count", count, 3);
    for (int i = 0; i < 5; i++) push(8'(8'h8B + i), 1'b1);
    idle(12, 1'b1);
    check_bursts("pp", 8'h80, 16, 8);

    // Asynchronous reset mid-cycle while full and presenting a burst.
    burst_size = 2'd0;
    for (int i = 0; i < 16; i++) push(8'(8'h90 + i), 1'b0);
    check("ar_pre_wfull", wfull, 1'b1);
    check("ar_pre_valid", dq_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", dq_valid, 1'b0);
    check("ar_wfull", wfull, 1'b0);
    check("ar_count", count, 0);
    check("ar_last",  dq_last, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    got.delete();
    idle(3, 1'b1);
    check("ar_after_valid", dq_valid, 1'b0);
    push(8'hA0, 1'b1);
    idle(4, 1'b1);
    check_bursts("ar_fresh", 8'hA0, 1, 1);

    idle(2, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
